// File: rtl/mem_arbiter_if.sv
// mem_arbiter_if: two requester ports plus the shared data-memory bus
interface mem_arbiter_if;
  logic        a_req, a_we, a_ack, a_err;
  logic [31:0] a_addr, a_wdata, a_rdata;
  logic        b_req, b_we, b_ack, b_err;
  logic [31:0] b_addr, b_wdata, b_rdata;
  logic [31:0] mem_address, mem_write_data, mem_read_data;
  logic        mem_read, mem_write, busy;
  modport master (
    output a_req, a_we, a_addr, a_wdata, b_req, b_we, b_addr, b_wdata, mem_read_data,
    input  a_ack, a_err, a_rdata, b_ack, b_err, b_rdata,
           mem_address, mem_write_data, mem_read, mem_write, busy
  );
  modport slave (
    input  a_req, a_we, a_addr, a_wdata, b_req, b_we, b_addr, b_wdata, mem_read_data,
    output a_ack, a_err, a_rdata, b_ack, b_err, b_rdata,
           mem_address, mem_write_data, mem_read, mem_write, busy
  );
endinterface

// File: rtl/mem_arbiter.sv
// mem_arbiter: round-robin arbiter sharing one registered-read data memory between ports A and B
module mem_arbiter #(
  parameter int NUM_CELLS = 32
) (
  input logic          clk,
  input logic          reset_n,
  mem_arbiter_if.slave bus
);
  localparam logic [1:0]  IDLE = 2'd0, ISSUE = 2'd1, CAPTURE = 2'd2, ACK = 2'd3;
  localparam logic [31:0] LIMIT = 32'(NUM_CELLS);
  logic [1:0]  state, next_state;
  logic        gnt_b, last_b, we, in_range, pick_b, issue, ack, rd_load;
  logic [31:0] addr, wdata, a_rdata, b_rdata, rd_next;
  assign in_range = addr < LIMIT;
  assign pick_b   = bus.b_req && (!bus.a_req || !last_b);
  assign issue    = state == ISSUE;
  assign ack      = state == ACK;
  // out-of-range reads complete with zero data, loaded while still in ISSUE
  assign rd_load  = state == CAPTURE || (issue && !we && !in_range);
  assign rd_next  = state == CAPTURE ? bus.mem_read_data : '0;
  always_comb
    next_state = state == IDLE    ? ((bus.a_req || bus.b_req) ? ISSUE : IDLE)
               : state == ISSUE   ? ((!we && in_range) ? CAPTURE : ACK)
               : state == CAPTURE ? ACK : IDLE;
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      state   <= IDLE;
      gnt_b   <= 1'b0;
      last_b  <= 1'b1;
      we      <= 1'b0;
      addr    <= '0;
      wdata   <= '0;
      a_rdata <= '0;
      b_rdata <= '0;
    end else begin
      state <= next_state;
      if (state == IDLE && (bus.a_req || bus.b_req)) begin
        gnt_b  <= pick_b;
        last_b <= pick_b;
        we     <= pick_b ? bus.b_we    : bus.a_we;
        addr   <= pick_b ? bus.b_addr  : bus.a_addr;
        wdata  <= pick_b ? bus.b_wdata : bus.a_wdata;
      end
      if (rd_load && gnt_b)  b_rdata <= rd_next;
      if (rd_load && !gnt_b) a_rdata <= rd_next;
    end
  assign bus.mem_address    = issue ? addr  : '0;
  assign bus.mem_write_data = issue ? wdata : '0;
  assign bus.mem_read       = issue && !we && in_range;
  assign bus.mem_write      = issue && we && in_range;
  assign bus.a_ack          = ack && !gnt_b;
  assign bus.b_ack          = ack && gnt_b;
  assign bus.a_err          = ack && !gnt_b && !in_range;
  assign bus.b_err          = ack && gnt_b && !in_range;
  assign bus.a_rdata        = a_rdata;
  assign bus.b_rdata        = b_rdata;
  assign bus.busy           = state != IDLE;
endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: directed and randomized checks of mem_arbiter against a transaction-level model
module tb_mem_arbiter;
  localparam int NC = 32;
  logic        clk = 1'b0, reset_n = 1'b0;
  logic        req [2], we [2];
  logic [31:0] addr [2], wd [2];
  logic [1:0]  ack_v, err_v;
  logic [31:0] rd_v [2];
  logic [31:0] mem [NC];
  logic [31:0] ref_mem [NC];
  logic [31:0] exp_rd [2];
  int          last, n_assert = 0, n_fail = 0;
  mem_arbiter_if bus ();
  mem_arbiter #(.NUM_CELLS(NC)) dut (.clk(clk), .reset_n(reset_n), .bus(bus));
  always #5 clk = ~clk;
  assign bus.a_req = req[0];
  assign bus.a_we = we[0];
  assign bus.a_addr = addr[0];
  assign bus.a_wdata = wd[0];
  assign bus.b_req = req[1];
  assign bus.b_we = we[1];
  assign bus.b_addr = addr[1];
  assign bus.b_wdata = wd[1];
  assign ack_v = {bus.b_ack, bus.a_ack};
  assign err_v = {bus.b_err, bus.a_err};
  assign rd_v[0] = bus.a_rdata;
  assign rd_v[1] = bus.b_rdata;
  function automatic logic [31:0] init_val(input int i);
    return 32'(i) * 32'h9E37_79B9 ^ 32'h5A5A_0F0F;
  endfunction
  // data memory with one-cycle registered read; stale read data is garbage
  always @(posedge clk)
    if (!reset_n) begin
      for (int i = 0; i < NC; i++) mem[i] <= init_val(i);
    end else begin
      if (bus.mem_write) mem[bus.mem_address[4:0]] <= bus.mem_write_data;
      bus.mem_read_data <= bus.mem_read ? mem[bus.mem_address[4:0]] : $urandom;
    end
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask
  task automatic reset_model();
    for (int i = 0; i < NC; i++) ref_mem[i] = init_val(i);
    exp_rd[0] = '0;
    exp_rd[1] = '0;
    last = 1;
  endtask
  task automatic do_reset();
    @(negedge clk);
    reset_n = 1'b0;
    req[0] = 1'b0;
    req[1] = 1'b0;
    @(negedge clk);
    reset_n = 1'b1;
    reset_model();
  endtask
  // wait for port p to complete the given access; extra = idle cycles expected before the grant
  task automatic expect_txn(input int p, input logic w, input logic [31:0] ad, input logic [31:0] d,
                            input int extra, input bit scr);
    int lat, nrd, nwr, o, exp_lat;
    bit inr, done;
    o = 1 - p;
    inr = ad < 32'(NC);
    exp_lat = (!w && inr) ? 3 + extra : 2 + extra;
    lat = 0; nrd = 0; nwr = 0; done = 0;
    while (!done && lat < 12) begin
      @(negedge clk);
      lat++;
      if (scr && lat == 1 + extra) begin
        we[p] = 1'($urandom);
        addr[p] = $urandom;
        wd[p] = $urandom;
      end
      chk("rw_exclusive", 32'(bus.mem_read && bus.mem_write), 0);
      chk("busy", 32'(bus.busy), 32'(lat > extra));
      chk("other_ack", 32'(ack_v[o]), 0);
      chk("other_err", 32'(err_v[o]), 0);
      chk("other_rdata", rd_v[o], exp_rd[o]);
      if (bus.mem_read) begin
        nrd++;
        chk("read_addr", bus.mem_address, ad);
      end
      if (bus.mem_write) begin
        nwr++;
        chk("write_addr", bus.mem_address, ad);
        chk("write_data", bus.mem_write_data, d);
      end
      if (ack_v[p]) done = 1;
    end
    chk("ack_latency", 32'(lat), 32'(exp_lat));
    chk("err", 32'(err_v[p]), 32'(!inr));
    if (w && inr) ref_mem[ad[4:0]] = d;
    if (!w) exp_rd[p] = inr ? ref_mem[ad[4:0]] : '0;
    chk("rdata", rd_v[p], exp_rd[p]);
    chk("read_strobes", 32'(nrd), 32'(!w && inr));
    chk("write_strobes", 32'(nwr), 32'(w && inr));
    last = p;
  endtask
  task automatic txn(input int p, input logic w, input logic [31:0] ad, input logic [31:0] d, input bit scr);
    @(negedge clk);
    we[p] = w;
    addr[p] = ad;
    wd[p] = d;
    req[p] = 1'b1;
    expect_txn(p, w, ad, d, 0, scr);
    req[p] = 1'b0;
  endtask
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end
  initial begin
    for (int i = 0; i < 2; i++) begin
      req[i] = 1'b0; we[i] = 1'b0; addr[i] = '0; wd[i] = '0;
    end
    reset_model();
    @(negedge clk);
    @(negedge clk);
    chk("rst_busy", 32'(bus.busy), 0);
    chk("rst_a_ack", 32'(bus.a_ack), 0);
    chk("rst_b_ack", 32'(bus.b_ack), 0);
    chk("rst_a_err", 32'(bus.a_err), 0);
    chk("rst_b_err", 32'(bus.b_err), 0);
    chk("rst_a_rdata", bus.a_rdata, 0);
    chk("rst_b_rdata", bus.b_rdata, 0);
    chk("rst_mem_read", 32'(bus.mem_read), 0);
    chk("rst_mem_write", 32'(bus.mem_write), 0);
    chk("rst_mem_address", bus.mem_address, 0);
    chk("rst_mem_wdata", bus.mem_write_data, 0);
    reset_n = 1'b1;
    txn(0, 1'b1, 32'd5, 32'hDEAD_BEEF, 0);
    txn(0, 1'b0, 32'd5, 32'h0, 0);
    txn(1, 1'b0, 32'd32, 32'h0, 0);
    txn(1, 1'b1, 32'd31, 32'h1234_5678, 0);
    txn(1, 1'b0, 32'd31, 32'h0, 0);
    txn(0, 1'b1, 32'hFFFF_FFF0, 32'hCAFE_F00D, 0);
    txn(0, 1'b0, 32'h8000_0005, 32'h0, 0);
    txn(1, 1'b0, 32'd0, 32'h0, 0);
    // A read in flight while B requests and then moves its address before being granted
    @(negedge clk);
    we[0] = 1'b0; addr[0] = 32'd5; req[0] = 1'b1;
    fork
      expect_txn(0, 1'b0, 32'd5, 32'h0, 0, 0);
      begin
        @(negedge clk);
        we[1] = 1'b0; addr[1] = 32'd7; req[1] = 1'b1;
        @(negedge clk);
        addr[1] = 32'd9;
      end
    join
    req[0] = 1'b0;
    expect_txn(1, 1'b0, 32'd9, 32'h0, 1, 0);
    req[1] = 1'b0;
    // back-to-back requests from one port with req held high through the ack
    @(negedge clk);
    we[0] = 1'b1; addr[0] = 32'd7; wd[0] = 32'h0BAD_CAFE; req[0] = 1'b1;
    expect_txn(0, 1'b1, 32'd7, 32'h0BAD_CAFE, 0, 0);
    we[0] = 1'b0;
    expect_txn(0, 1'b0, 32'd7, 32'h0, 1, 0);
    req[0] = 1'b0;
    // reset pulsed while a read sits in CAPTURE
    @(negedge clk);
    we[0] = 1'b0; addr[0] = 32'd3; req[0] = 1'b1;
    @(negedge clk);
    chk("mid_issue_read", 32'(bus.mem_read), 1);
    @(negedge clk);
    reset_n = 1'b0;
    #1;
    chk("abort_busy", 32'(bus.busy), 0);
    chk("abort_a_ack", 32'(bus.a_ack), 0);
    chk("abort_a_rdata", bus.a_rdata, 0);
    chk("abort_b_rdata", bus.b_rdata, 0);
    chk("abort_mem_read", 32'(bus.mem_read), 0);
    chk("abort_mem_address", bus.mem_address, 0);
    req[0] = 1'b0;
    @(negedge clk);
    chk("abort_no_ack", 32'(ack_v), 0);
    reset_n = 1'b1;
    reset_model();
    txn(0, 1'b0, 32'd3, 32'h0, 0);
    for (int k = 0; k < 30; k++)
      txn(int'($urandom_range(0, 1)), 1'($urandom),
          ($urandom_range(0, 7) == 0) ? $urandom : 32'($urandom_range(0, NC + 2)), $urandom, 1);
    // both ports request continuously from reset: grants must alternate starting with A
    do_reset();
    @(negedge clk);
    for (int i = 0; i < 2; i++) begin
      we[i] = 1'($urandom); addr[i] = 32'($urandom_range(0, NC + 3)); wd[i] = $urandom; req[i] = 1'b1;
    end
    for (int k = 0; k < 24; k++) begin
      int p;
      p = 1 - last;
      expect_txn(p, we[p], addr[p], wd[p], (k == 0) ? 0 : 1, 0);
      we[p] = 1'($urandom);
      addr[p] = 32'($urandom_range(0, NC + 3));
      wd[p] = $urandom;
    end
    req[0] = 1'b0;
    req[1] = 1'b0;
    repeat (3) @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameter NUM_CELLS, default 32, number of valid memory words; legal addresses are 0..NUM_CELLS-1.
REQ-002 Clk  input  1  single clock; all state changes on its rising edge.
REQ-003 Reset_n  input  1  asynchronous, active-low reset.
REQ-004 AReq  input  1  port A request; held high with fields stable until AAck.
REQ-005 AWe  input  1  port A operation: 1 = write, 0 = read.
REQ-006 AAddr  input  32  port A word address.
REQ-007 AWData  input  32  port A write data.
REQ-008 AAck  output  1  port A one-cycle completion pulse.
REQ-009 ARData  output  32  port A read data; valid while AAck=1.
REQ-010 AErr  output  1  port A out-of-range flag; valid while AAck=1.
REQ-011 BReq, BWe, BAddr, BWData, BAck, BRData, BErr: port B equivalents with identical widths and meanings.
REQ-012 MemAddress  output  32  address to the data memory.
REQ-013 MemWriteData  output  32  write data to the data memory.
REQ-014 MemRead  output  1  memory read strobe.
REQ-015 MemWrite  output  1  memory write strobe.
REQ-016 MemReadData  input  32  memory read data; registered by the memory, so valid the cycle after MemRead.
REQ-017 Busy  output  1  high in every state except IDLE.

Function
REQ-018 The FSM SHALL have four states: IDLE, ISSUE, CAPTURE, ACK.
REQ-019 IDLE: if any Req is high, the arbiter SHALL grant one port, latch that port's We/Addr/WData into internal registers, and go to ISSUE.
REQ-020 Arbitration is round-robin: with both Req high, the port not granted most recently wins; with one Req high, that port wins.
REQ-021 ISSUE (exactly one cycle): MemAddress/MemWriteData = latched values; MemRead = !We and MemWrite = We, both gated by Addr < NUM_CELLS.
REQ-022 From ISSUE: in-range read -> CAPTURE; write or out-of-range access -> ACK.
REQ-023 CAPTURE (one cycle, no strobes): MemReadData SHALL be registered into the granted port's RData at the cycle's end; next state ACK.
REQ-024 ACK (one cycle): granted port's Ack = 1, Err = (Addr >= NUM_CELLS); next state IDLE.
REQ-025 Out-of-range reads return RData = 0; out-of-range writes never assert MemWrite.
REQ-026 Latency from Req sampled in IDLE to Ack: 3 cycles for in-range reads, 2 cycles for writes and errors.
REQ-027 MemRead and MemWrite SHALL be 0 in every state except ISSUE, and never high together.
REQ-028 The non-granted port's Ack, Err and RData SHALL be unchanged during the grant; RData holds its last value until that port's next read completes.
REQ-029 A Req arriving while Busy SHALL wait; changes to the granted port's inputs after the grant SHALL have no effect.
REQ-030 A Req still high in the IDLE cycle after Ack SHALL be treated as a new request.
REQ-031 Address comparison is unsigned over the full 32 bits; MemAddress carries the full 32-bit address.

Reset
REQ-032 Reset_n low SHALL immediately force IDLE, Busy=0, MemRead=MemWrite=0, MemAddress=MemWriteData=0, AAck=BAck=0, AErr=BErr=0, ARData=BRData=0, with last-grant = B so that A wins the first tie.
REQ-033 Reset asserted mid-transaction SHALL abort it with no Ack; a strobe not yet sampled by the memory SHALL not occur.

Verification
REQ-034 A writes Addr=5, WData=0xDEADBEEF -> MemWrite high exactly one cycle with MemAddress=5; AAck 2 cycles after grant; then A reads 5 -> ARData=0xDEADBEEF with AAck 3 cycles after grant.
REQ-035 A and B both request continuously from reset -> grants alternate A, B, A, B; each Ack is a single-cycle pulse; MemRead and MemWrite are never high together.
REQ-036 B reads Addr=32 (NUM_CELLS=32) -> no MemRead; BAck with BErr=1 and BRData=0 two cycles after grant.
REQ-037 A's read is in flight while B requests and B changes its Addr -> B waits; B is granted the IDLE cycle after AAck and uses the Addr present at grant; ARData is unaffected by B.
REQ-038 Reset_n pulsed low during CAPTURE -> outputs go to reset values asynchronously; no AAck; the next request completes normally.
